// File: rtl/nrd_divider_sgn.sv
`default_nettype none
// ============================================================================
// Module   : nrd_divider_sgn
// Brief    : Sequential non-restoring divider that produces one quotient bit
//            per clock. Supports signed or unsigned operation per request,
//            valid/ready handshakes on both sides, and divide-by-zero and
//            signed-overflow flags.
//            Optional feature macro: NRD_ABORT_EN adds an abort input that
//            cancels an operation while it is in PREP, ITER or FIX.
// Revision : 1.0 - initial release
// ============================================================================
module nrd_divider_sgn #(
    parameter int WIDTH = 256,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef NRD_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] c_min_val = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_a;        // partial remainder, two's complement
    logic [WIDTH-1:0]   r_q;        // quotient shift register / staged quotient
    logic [WIDTH:0]     r_m;        // divisor magnitude, zero-extended
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_v;
    logic               r_sgn;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dz_pend;
    logic               r_ov_pend;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dz;
    logic               r_ov;

    logic               w_abort;
    logic               w_d_neg;
    logic               w_v_neg;
    logic [WIDTH-1:0]   w_d_mag;
    logic [WIDTH-1:0]   w_v_mag;
    logic [WIDTH:0]     w_a_sh;
    logic [WIDTH:0]     w_a_step;
    logic [WIDTH-1:0]   w_a_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_rem_fix;

`ifdef NRD_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Operand signs only matter in signed mode; MIN's magnitude fits unsigned.
    assign w_d_neg = r_sgn & r_d[WIDTH-1];
    assign w_v_neg = r_sgn & r_v[WIDTH-1];
    assign w_d_mag = w_d_neg ? -r_d : r_d;
    assign w_v_mag = w_v_neg ? -r_v : r_v;

    // One non-restoring step: shift {A,Q}, then subtract or add M by old sign.
    assign w_a_sh   = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_a_step = r_a[WIDTH] ? (w_a_sh + r_m) : (w_a_sh - r_m);

    // Final correction of a negative remainder and sign restoration.
    assign w_a_fix   = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_m[WIDTH-1:0]) : r_a[WIDTH-1:0];
    assign w_q_fix   = r_sign_q ? -r_q : r_q;
    assign w_rem_fix = (r_sign_r && (w_a_fix != '0)) ? -w_a_fix : w_a_fix;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;

    // Control FSM and datapath; results are published one cycle after DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_d         <= '0;
            r_v         <= '0;
            r_sgn       <= 1'b0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dz_pend   <= 1'b0;
            r_ov_pend   <= 1'b0;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_d     <= dividend;
                        r_v     <= divisor;
                        r_sgn   <= in_signed;
                        r_dz    <= 1'b0;
                        r_ov    <= 1'b0;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_sign_q <= w_d_neg ^ w_v_neg;
                        r_sign_r <= w_d_neg;
                        r_m      <= {1'b0, w_v_mag};
                        r_cnt    <= '0;
                        if (r_v == '0) begin
                            r_q       <= '1;
                            r_a       <= {1'b0, r_d};
                            r_dz_pend <= 1'b1;
                            r_ov_pend <= 1'b0;
                            r_state   <= S_DONE;
                        end else if (r_sgn && (r_d == c_min_val) && (r_v == '1)) begin
                            r_q       <= c_min_val;
                            r_a       <= '0;
                            r_dz_pend <= 1'b0;
                            r_ov_pend <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_q       <= w_d_mag;
                            r_a       <= '0;
                            r_dz_pend <= 1'b0;
                            r_ov_pend <= 1'b0;
                            r_state   <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    if (w_abort) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_a <= w_a_step;
                        r_q <= {r_q[WIDTH-2:0], ~w_a_step[WIDTH]};
                        if (r_cnt == CNT_W'(WIDTH - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FIX: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_a     <= {1'b0, w_rem_fix};
                        r_q     <= w_q_fix;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_quotient  <= r_q;
                        r_remainder <= r_a[WIDTH-1:0];
                        r_dz        <= r_dz_pend;
                        r_ov        <= r_ov_pend;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nrd_divider_sgn.sv
`default_nettype none
// ============================================================================
// Module   : tb_nrd_divider_sgn
// Brief    : Self-checking bench for nrd_divider_sgn at WIDTH=8 with directed
//            and random operations against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nrd_divider_sgn;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_signed = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;
`ifdef NRD_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    logic         eov;
    int           elat;

    nrd_divider_sgn #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef NRD_ABORT_EN
        .abort       (abort),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    task automatic set_exp(input logic s, input logic [W-1:0] d, input logic [W-1:0] v);
        int di;
        int vi;
        edz = 1'b0;
        eov = 1'b0;
        if (v == 0) begin
            eq  = '1;
            er  = d;
            edz = 1'b1;
        end else if (s && d == 8'h80 && v == 8'hFF) begin
            eq  = 8'h80;
            er  = 8'h00;
            eov = 1'b1;
        end else if (s) begin
            di = $signed(d);
            vi = $signed(v);
            eq = 8'(di / vi);
            er = 8'(di % vi);
        end else begin
            di = int'(d);
            vi = int'(v);
            eq = 8'(di / vi);
            er = 8'(di % vi);
        end
        elat = (edz || eov) ? 2 : W + 3;
    endtask

    // Offers one operation; returns 1 time unit after the accepting edge.
    task automatic start_op(input logic s, input logic [W-1:0] d, input logic [W-1:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_signed = s;
        dividend  = d;
        divisor   = v;
        set_exp(s, d, v);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_signed = 1'($urandom);
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_result();
        int lat;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(edz));
        chk("overflow", 32'(overflow), 32'(eov));
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("quotient_hold", 32'(quotient), 32'(eq));
    endtask

    initial begin
        logic          s;
        logic [W-1:0]  d;
        logic [W-1:0]  v;
        logic [W-1:0]  vs [6];
        logic [W-1:0]  ds [6];
        logic          ss [6];

        // Reset values
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors: unsigned, signed mixes, divide-by-zero, overflow
        ss = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        ds = '{8'd200, 8'h9C, 8'h64, 8'h55, 8'h55, 8'h80};
        vs = '{8'd7, 8'h07, 8'hF9, 8'h00, 8'h00, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            start_op(ss[i], ds[i], vs[i]);
            wait_result();
            handshake();
        end
        start_op(1'b1, 8'h80, 8'hFF);
        wait_result();
        handshake();

        // Back-pressure hold, then an offer on the handshake cycle
        start_op(1'b1, 8'h9C, 8'h07);
        wait_result();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_quotient", 32'(quotient), 32'(eq));
            chk("hold_remainder", 32'(remainder), 32'(er));
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_signed = 1'b0;
        dividend  = 8'd200;
        divisor   = 8'd7;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_valid_drop", 32'(out_valid), 32'd0);
        chk("hs_not_accepted", 32'(in_ready), 32'd1);
        set_exp(1'b0, 8'd200, 8'd7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("late_accept", 32'(in_ready), 32'd0);
        wait_result();
        handshake();

        // Asynchronous reset in the middle of iteration
        start_op(1'b0, 8'd200, 8'd7);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        start_op(1'b1, 8'h64, 8'hF9);
        wait_result();
        handshake();

`ifdef NRD_ABORT_EN
        // Abort during iteration: no result, then a clean operation
        start_op(1'b0, 8'd99, 8'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_result", 32'(out_valid), 32'd0);
        start_op(1'b0, 8'd15, 8'd4);
        wait_result();
        handshake();
`endif

        // Random operations with periodic special cases
        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom);
            d = W'($urandom);
            v = W'($urandom);
            if (i % 10 == 0) v = 8'h00;
            if (i % 10 == 5) begin
                s = 1'b1;
                d = 8'h80;
                v = 8'hFF;
            end
            start_op(s, d, v);
            wait_result();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            chk("rand_hold_q", 32'(quotient), 32'(eq));
            handshake();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
